pulse_timer_gen: RTL
====================

PULSE_TIMER_GEN -- requirements
Module: pulse_timer_gen

Interface
REQ-001 Parameter Z, default 11: width of the tick counter q and of the duration inputs.
REQ-002 Parameter N, default 16: width of the prescaler and NTclk.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 st  in  1  start request, sampled each posedge.
REQ-006 stop  in  1  synchronous abort.
REQ-007 mode  in  2  00 one-shot, 01 retriggerable, 10 periodic, 11 treated as one-shot.
REQ-008 NTclk  in  N  prescaler divisor, in clk cycles per tick; 0 behaves as 1.
REQ-009 MD  in  Z  delay ticks before the pulse; 0 means no delay phase.
REQ-010 MT  in  Z  pulse-width ticks; 0 behaves as 1.
REQ-011 MG  in  Z  gap ticks between periodic pulses; 0 means no gap.
REQ-012 q  out  Z  current phase down-counter, registered.
REQ-013 PW  out  1  pulse output, registered, high only in PULSE.
REQ-014 end_PW  out  1  combinational, equals PW & (q==1).
REQ-015 ceo  out  1  prescaler tick ce delayed one clk.
REQ-016 busy  out  1  registered, high whenever state != IDLE.
REQ-017 done  out  1  one-clk strobe marking the end of each pulse.

Function
REQ-018 States: IDLE, DELAY, PULSE, GAP.
REQ-019 Prescaler cb_ce (N bits): ce = (cb_ce == NTe), where NTe is the latched max(NTclk,1); cb_ce loads 1 on accepted start or ce, otherwise increments.
REQ-020 Accepted start: st=1 and stop=0, and either state=IDLE or (mode_l=01 and state in DELAY/PULSE); st in other states is ignored.
REQ-021 On accepted start, latch mode, NTclk, MD, MT and MG; if MD!=0, go to DELAY with q=MD and PW=0; else go to PULSE with q=max(MT,1) and PW=1.
REQ-022 Countdown: in DELAY, PULSE and GAP, each ce with q>1 does q<=q-1.
REQ-023 DELAY with ce and q==1: go to PULSE, q=max(MT_l,1), PW=1.
REQ-024 PULSE with ce and q==1: done=1 for one clk.
REQ-025 Following REQ-024 in one-shot or retriggerable mode: go to IDLE with q=0 and PW=0.
REQ-026 Following REQ-024 in periodic mode with MG_l!=0: go to GAP with q=MG_l and PW=0.
REQ-027 Following REQ-024 in periodic mode with MG_l=0: reload q=max(MT_l,1) and hold PW=1 continuously.
REQ-028 GAP with ce and q==1: go to PULSE, q=max(MT_l,1), PW=1.
REQ-029 Timing: with accepted start at edge k and MD=0, PW is high for exactly MT*NTe cycles, edges k..k+MT*NTe; with MD>0, PW rises at edge k+MD*NTe.
REQ-030 Retrigger during PULSE with MD=0 reloads q=MT and restarts the prescaler, with no PW glitch and no done.
REQ-031 stop=1: next edge forces IDLE, q=0, PW=0, busy=0, done=0 and cb_ce=1; stop has priority over st and over any ce event.
REQ-032 Simultaneous accepted retrigger and terminal ce: the retrigger wins and done is not asserted.
REQ-033 No arithmetic wraps: q never decrements below 1 and reloads only per REQ-021..REQ-028; MT=0 yields a 1-tick pulse.

Reset
REQ-034 rst=1 at a posedge: state=IDLE, q=0, PW=0, ceo=0, busy=0, done=0, cb_ce=0 and all latched parameters cleared.
REQ-035 rst has priority over stop and st and takes effect mid-operation in any state.
REQ-036 In the first cycle after rst deasserts, the block accepts st normally.

Verification
REQ-037 One-shot, NTclk=3, MD=0, MT=4, st pulse -> PW high 12 clks, done at the falling edge, end_PW high during the last 3 clks, busy drops with PW.
REQ-038 Delay, NTclk=2, MD=3, MT=2 -> PW rises 6 clks after start and stays high 4 clks; busy is high for 10 clks.
REQ-039 Periodic, NTclk=1, MT=2, MG=3 -> PW pattern 2 high / 3 low repeats; done on every pulse end; st while running is ignored.
REQ-040 Retriggerable, NTclk=1, MT=5, st again 3 clks after the first -> PW continuous 8 clks and a single done.
REQ-041 Abort/reset: stop mid-PULSE -> PW=0 and busy=0 next clk with no done; rst in GAP -> all outputs 0 next clk.
REQ-042 Edge values: NTclk=0 and MT=0 -> 1-clk pulse; st and stop in the same clk -> stays IDLE.

Source files
------------

// File: rtl/pulse_timer_gen.sv
// Prescaled pulse timer: optional delay, then a pulse of MT ticks, then one-shot, retriggerable or periodic repeat.
// State updates every clk; a tick (ce) occurs every NTe clks. No backpressure.
module pulse_timer_gen #(
  parameter int Z = 11,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [N-1:0] NTclk,
  input  logic [Z-1:0] MD,
  input  logic [Z-1:0] MT,
  input  logic [Z-1:0] MG,
  output logic [Z-1:0] q,
  output logic         PW,
  output logic         end_PW,
  output logic         ceo,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

  localparam logic [1:0] MODE_RETRIG   = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;

  state_t       state, state_nxt;
  logic [Z-1:0] q_nxt;
  logic         pw_nxt, done_nxt;
  logic [N-1:0] cb_ce, cb_nxt;
  logic [N-1:0] nte, nte_nxt;
  logic [1:0]   mode_l, mode_nxt;
  logic [Z-1:0] md_l, md_nxt, mt_l, mt_nxt, mg_l, mg_nxt;

  logic         ce;
  logic         start_ok;
  logic [Z-1:0] mt_in_eff, mt_l_eff;

  assign ce        = (cb_ce == nte);
  assign mt_in_eff = (MT == '0) ? Z'(1) : MT;
  assign mt_l_eff  = (mt_l == '0) ? Z'(1) : mt_l;

  // A retriggerable run may be restarted while still timing (delay or pulse), never in GAP.
  assign start_ok = st && !stop &&
                    ((state == IDLE) ||
                     ((mode_l == MODE_RETRIG) && ((state == DELAY) || (state == PULSE))));

  assign end_PW = PW && (q == Z'(1));

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    pw_nxt    = PW;
    done_nxt  = 1'b0;
    cb_nxt    = cb_ce + N'(1);
    mode_nxt  = mode_l;
    nte_nxt   = nte;
    md_nxt    = md_l;
    mt_nxt    = mt_l;
    mg_nxt    = mg_l;

    if (stop) begin
      state_nxt = IDLE;
      q_nxt     = '0;
      pw_nxt    = 1'b0;
      cb_nxt    = N'(1);
    end else if (start_ok) begin
      mode_nxt = mode;
      nte_nxt  = (NTclk == '0) ? N'(1) : NTclk;
      md_nxt   = MD;
      mt_nxt   = MT;
      mg_nxt   = MG;
      cb_nxt   = N'(1);
      if (MD != '0) begin
        state_nxt = DELAY;
        q_nxt     = MD;
        pw_nxt    = 1'b0;
      end else begin
        state_nxt = PULSE;
        q_nxt     = mt_in_eff;
        pw_nxt    = 1'b1;
      end
    end else begin
      if (ce) begin
        cb_nxt = N'(1);
      end
      if (ce && (state != IDLE)) begin
        if (q > Z'(1)) begin
          q_nxt = q - Z'(1);
        end else begin
          unique case (state)
            DELAY, GAP: begin
              state_nxt = PULSE;
              q_nxt     = mt_l_eff;
              pw_nxt    = 1'b1;
            end
            PULSE: begin
              done_nxt = 1'b1;
              if (mode_l == MODE_PERIODIC) begin
                if (mg_l != '0) begin
                  state_nxt = GAP;
                  q_nxt     = mg_l;
                  pw_nxt    = 1'b0;
                end else begin
                  q_nxt  = mt_l_eff;
                  pw_nxt = 1'b1;
                end
              end else begin
                state_nxt = IDLE;
                q_nxt     = '0;
                pw_nxt    = 1'b0;
              end
            end
            default: begin
              state_nxt = IDLE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      PW     <= 1'b0;
      ceo    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cb_ce  <= '0;
      nte    <= '0;
      mode_l <= '0;
      md_l   <= '0;
      mt_l   <= '0;
      mg_l   <= '0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      PW     <= pw_nxt;
      ceo    <= ce;
      busy   <= (state_nxt != IDLE);
      done   <= done_nxt;
      cb_ce  <= cb_nxt;
      nte    <= nte_nxt;
      mode_l <= mode_nxt;
      md_l   <= md_nxt;
      mt_l   <= mt_nxt;
      mg_l   <= mg_nxt;
    end
  end

endmodule
